// File: rtl/mp_out.sv
// MP_out: collects four ciphertext words into a 128-bit frame and
// streams it out MSB-first as 16 bytes through a UART handshake.
module mp_out #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] MP_cipher_in,
    input  logic                  MP_dv_in,
    input  logic                  TX_done_in,
    output logic [7:0]            uart_byte_out,
    output logic                  TX_DV_out,
    output logic                  MP_busy_out,
    output logic                  MP_done_out,
    output logic                  MP_overrun_out
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT,
        DONE
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [127:0] buffer;
    logic [1:0]   wcnt;
    logic [3:0]   k;
    logic [7:0]   byte_q;
    logic [7:0]   cur_byte;
    logic         accept;
    logic         in_tx;

    assign accept = MP_dv_in && (state == IDLE || state == LOAD);
    assign in_tx  = (state == SEND) || (state == WAIT) || (state == DONE);

    // Select byte k of the frame, byte 0 being the top of the buffer
    always_comb begin
        cur_byte = 8'h00;
        for (int i = 0; i < 16; i++) begin
            if (k == i[3:0]) begin
                cur_byte = buffer[127-8*i -: 8];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (MP_dv_in) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (MP_dv_in && wcnt == 2'd3) begin
                    state_nxt = SEND;
                end
            end
            SEND: state_nxt = WAIT;
            WAIT: begin
                if (TX_done_in) begin
                    state_nxt = (k == 4'd15) ? DONE : SEND;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Frame buffer, word counter, byte index and held output byte
    always_ff @(posedge clk) begin
        if (rst) begin
            buffer <= '0;
            wcnt   <= '0;
            k      <= '0;
            byte_q <= '0;
        end else begin
            if (accept) begin
                buffer <= {buffer[127-DATA_WIDTH:0], MP_cipher_in};
                wcnt   <= wcnt + 2'd1;
            end
            if (state == SEND) begin
                byte_q <= cur_byte;
            end
            if (state == WAIT && TX_done_in && k != 4'd15) begin
                k <= k + 4'd1;
            end
            if (state == DONE) begin
                wcnt <= '0;
                k    <= '0;
            end
        end
    end

    // Moore outputs; the byte bus keeps its last value outside SEND
    always_comb begin
        TX_DV_out      = (state == SEND);
        uart_byte_out  = (state == SEND) ? cur_byte : byte_q;
        MP_busy_out    = (state != IDLE);
        MP_done_out    = (state == DONE);
        MP_overrun_out = MP_dv_in && in_tx && !rst;
    end

endmodule

// File: tb/tb_mp_out.sv
// Directed bench for mp_out: nominal, gapped, overrun, mid-frame
// reset, coincident done and back-to-back frames.
module tb_mp_out;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] MP_cipher_in;
    logic        MP_dv_in;
    logic        TX_done_in;
    logic [7:0]  uart_byte_out;
    logic        TX_DV_out;
    logic        MP_busy_out;
    logic        MP_done_out;
    logic        MP_overrun_out;

    logic auto_done = 1'b0;
    logic man_done  = 1'b0;
    logic auto_en   = 1'b1;
    assign TX_done_in = auto_done | man_done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int ovr_cnt = 0;
    int cd = 0;
    logic prev_dv = 1'b0;
    logic [7:0] q[$];

    logic [31:0] words [4] = '{32'h3925841D, 32'h02DC09FB,
                               32'hDC118597, 32'h196A0B32};
    logic [7:0] expb [16] = '{8'h39, 8'h25, 8'h84, 8'h1D,
                              8'h02, 8'hDC, 8'h09, 8'hFB,
                              8'hDC, 8'h11, 8'h85, 8'h97,
                              8'h19, 8'h6A, 8'h0B, 8'h32};

    mp_out #(.DATA_WIDTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .MP_cipher_in   (MP_cipher_in),
        .MP_dv_in       (MP_dv_in),
        .TX_done_in     (TX_done_in),
        .uart_byte_out  (uart_byte_out),
        .TX_DV_out      (TX_DV_out),
        .MP_busy_out    (MP_busy_out),
        .MP_done_out    (MP_done_out),
        .MP_overrun_out (MP_overrun_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Monitor and UART responder: records bytes, answers each strobe
    // with a done pulse three cycles later when auto_en is set.
    always @(negedge clk) begin
        #2;
        auto_done = 1'b0;
        if (rst) begin
            cd = 0;
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) auto_done = 1'b1;
        end
        if (TX_DV_out) begin
            check("dv_gap", 32'(prev_dv), 0);
            q.push_back(uart_byte_out);
            if (auto_en) cd = 3;
        end
        prev_dv = TX_DV_out;
        if (MP_done_out) done_cnt++;
        if (MP_overrun_out) ovr_cnt++;
    end

    task automatic send_frame(input int gap, input string tag);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            MP_dv_in = 1'b1;
            MP_cipher_in = words[i];
            if (i < 3) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    MP_dv_in = 1'b0;
                    check({tag, "_busy"}, 32'(MP_busy_out), 1);
                end
            end
        end
        @(negedge clk);
        MP_dv_in = 1'b0;
        check({tag, "_lat"}, 32'(TX_DV_out), 1);
        check({tag, "_b0"}, 32'(uart_byte_out), 32'h39);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!MP_done_out && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, 32'(MP_done_out), 1);
    endtask

    task automatic wait_dv(input int target, input string tag);
        int n;
        int c;
        n = 1;
        c = 0;
        while (n < target && c < 200) begin
            @(negedge clk);
            c++;
            if (TX_DV_out) n++;
        end
        check({tag, "_dvcnt"}, 32'(n), 32'(target));
    endtask

    task automatic check_stream(input string tag, input int nf);
        check({tag, "_len"}, 32'(q.size()), 32'(16 * nf));
        for (int i = 0; i < q.size() && i < 16 * nf; i++) begin
            check($sformatf("%s_byte%0d", tag, i), 32'(q[i]),
                  32'(expb[i % 16]));
        end
    endtask

    initial begin
        int sz;
        int dc;
        rst = 1'b1;
        MP_dv_in = 1'b1;
        MP_cipher_in = 32'hDEADBEEF;
        repeat (2) @(negedge clk);
        check("rst_byte", 32'(uart_byte_out), 0);
        check("rst_dv", 32'(TX_DV_out), 0);
        check("rst_busy", 32'(MP_busy_out), 0);
        check("rst_done", 32'(MP_done_out), 0);
        check("rst_ovr", 32'(MP_overrun_out), 0);
        rst = 1'b0;
        MP_dv_in = 1'b0;
        @(negedge clk);
        check("rst_dv_ignored", 32'(MP_busy_out), 0);

        // nominal frame
        q.delete(); done_cnt = 0; ovr_cnt = 0;
        send_frame(0, "nom");
        wait_done("nom");
        @(negedge clk);
        check("nom_idle", 32'(MP_busy_out), 0);
        check_stream("nom", 1);
        check("nom_donecnt", 32'(done_cnt), 1);
        check("nom_ovrcnt", 32'(ovr_cnt), 0);

        // gapped load
        q.delete(); done_cnt = 0;
        send_frame(2, "gap");
        wait_done("gap");
        @(negedge clk);
        check_stream("gap", 1);
        check("gap_donecnt", 32'(done_cnt), 1);

        // overrun during byte 5 wait
        q.delete(); done_cnt = 0; ovr_cnt = 0;
        send_frame(0, "ovr");
        wait_dv(6, "ovr");
        @(negedge clk);
        MP_dv_in = 1'b1;
        MP_cipher_in = 32'hFFFFFFFF;
        #1 check("ovr_pulse", 32'(MP_overrun_out), 1);
        @(negedge clk);
        MP_dv_in = 1'b0;
        #1 check("ovr_end", 32'(MP_overrun_out), 0);
        wait_done("ovr");
        @(negedge clk);
        check_stream("ovr", 1);
        check("ovr_cnt", 32'(ovr_cnt), 1);

        // reset mid-frame after byte 7
        q.delete(); done_cnt = 0;
        send_frame(0, "mrst");
        wait_dv(8, "mrst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_byte", 32'(uart_byte_out), 0);
        check("mrst_dv", 32'(TX_DV_out), 0);
        check("mrst_busy", 32'(MP_busy_out), 0);
        check("mrst_done", 32'(MP_done_out), 0);
        check("mrst_ovr", 32'(MP_overrun_out), 0);
        sz = q.size();
        dc = done_cnt;
        repeat (20) @(negedge clk);
        check("mrst_nodv", 32'(q.size()), 32'(sz));
        check("mrst_nodone", 32'(done_cnt), 32'(dc));
        q.delete();
        send_frame(0, "mrst2");
        wait_done("mrst2");
        @(negedge clk);
        check_stream("mrst2", 1);

        // TX_done coincident with TX_DV
        q.delete(); done_cnt = 0;
        auto_en = 1'b0;
        send_frame(0, "coin");
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        check("coin_wait0", 32'(TX_DV_out), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("coin_wait", 32'(TX_DV_out), 0);
            check("coin_busy", 32'(MP_busy_out), 1);
        end
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        auto_en = 1'b1;
        check("coin_dv", 32'(TX_DV_out), 1);
        check("coin_b1", 32'(uart_byte_out), 32'h25);
        wait_done("coin");
        @(negedge clk);
        check_stream("coin", 1);

        // back-to-back frames
        q.delete(); done_cnt = 0;
        send_frame(0, "b2b1");
        wait_done("b2b1");
        send_frame(0, "b2b2");
        wait_done("b2b2");
        @(negedge clk);
        check_stream("b2b", 2);
        check("b2b_donecnt", 32'(done_cnt), 2);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/mp_out.md
MP_OUT -- requirements
Module: MP_out

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, giving the width of the parallel word input.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: the reset, synchronous and active-high.
REQ-004 The module SHALL have port MP_cipher_in, input, DATA_WIDTH bits: ciphertext word, most-significant word first.
REQ-005 The module SHALL have port MP_dv_in, input, 1 bit: MP_cipher_in is valid this cycle.
REQ-006 The module SHALL have port TX_done_in, input, 1 bit: one-cycle pulse from the UART transmitter when a byte has been fully sent.
REQ-007 The module SHALL have port uart_byte_out, output, 8 bits: byte presented to the UART transmitter.
REQ-008 The module SHALL have port TX_DV_out, output, 1 bit: one-cycle strobe that starts transmission of uart_byte_out.
REQ-009 The module SHALL have port MP_busy_out, output, 1 bit: high in every state except IDLE.
REQ-010 The module SHALL have port MP_done_out, output, 1 bit: one-cycle pulse after the 16th byte completes.
REQ-011 The module SHALL have port MP_overrun_out, output, 1 bit: one-cycle pulse when MP_dv_in is dropped.

Function
REQ-012 The FSM SHALL have the states IDLE, LOAD, SEND, WAIT and DONE.
REQ-013 In IDLE and LOAD, each cycle with MP_dv_in=1 SHALL shift MP_cipher_in into a 128-bit buffer from the LSW end and increment a 2-bit word counter.
- The first word received ends in bits [127:96].
- Words need not be on consecutive cycles.
REQ-014 IDLE SHALL go to LOAD on the first valid word.
REQ-015 LOAD SHALL go to SEND on the cycle the 4th word is captured (word counter wraps 3->0).
REQ-016 In SEND, the module SHALL, for one cycle, drive TX_DV_out=1 and uart_byte_out = buffer[127-8*k -: 8], where k is the byte index 0..15, then go to WAIT.
- Byte 0 is the MSB of the first word.
REQ-017 In WAIT, TX_done_in=1 SHALL either go to SEND with k+1, or go to DONE if k=15.
- TX_done_in is ignored in every other state.
REQ-018 Latency: the first TX_DV_out SHALL occur on the cycle after the 4th word is captured.
- Each following TX_DV_out occurs on the cycle after the TX_done_in that completes the previous byte.
REQ-019 DONE SHALL assert MP_done_out for exactly one cycle, then go to IDLE with the word counter and k cleared.
REQ-020 In SEND, WAIT and DONE, MP_dv_in=1 SHALL be ignored: the buffer and counters are not modified, and MP_overrun_out is pulsed that cycle.
REQ-021 uart_byte_out SHALL hold its last value when TX_DV_out=0; TX_DV_out SHALL never be high for two consecutive cycles.
REQ-022 A TX_done_in pulse that arrives in the same cycle as TX_DV_out SHALL be ignored and SHALL NOT advance k.
REQ-023 The byte index k SHALL be 4 bits and SHALL NOT wrap within a frame; exactly 16 TX_DV_out pulses occur per frame.

Reset
REQ-024 rst=1 at a clock edge SHALL force state IDLE and clear all of the following to 0: the buffer, word counter, k, uart_byte_out, TX_DV_out, MP_busy_out, MP_done_out and MP_overrun_out.
REQ-025 Reset asserted mid-frame (in LOAD, SEND or WAIT) SHALL abandon the frame with no further TX_DV_out, and SHALL NOT produce MP_done_out.
REQ-026 A MP_dv_in or TX_done_in arriving in the same cycle as rst=1 SHALL be ignored.

Verification
REQ-027 Nominal frame: drive 3925841D, 02DC09FB, DC118597, 196A0B32 on 4 consecutive cycles, and answer each TX_DV_out with TX_done_in 3 cycles later.
- Required: 16 bytes in the order 39 25 84 1D 02 DC 09 FB DC 11 85 97 19 6A 0B 32.
- First TX_DV_out appears 1 cycle after the 4th word.
- A single MP_done_out pulse follows the 16th TX_done_in.
REQ-028 Gapped load: drive the same words with 2 idle cycles between each.
- Required: identical byte stream.
- MP_busy_out is high from the first word onward.
REQ-029 Overrun: drive MP_dv_in=1 with FFFFFFFF during byte 5 WAIT.
- Required: MP_overrun_out pulses for 1 cycle.
- The remaining bytes are unchanged from REQ-027.
REQ-030 Reset mid-frame: assert rst for 1 cycle after byte 7 is sent.
- Required: all outputs are 0 on the next cycle and no further TX_DV_out is produced.
- A new 4-word frame afterwards transmits correctly starting from byte 0.
REQ-031 Coincident done: pulse TX_done_in in the same cycle as TX_DV_out.
- Required: k does not advance.
- The module waits in WAIT for a later TX_done_in before sending the next byte.
REQ-032 Back-to-back frames: start a second frame on the cycle after MP_done_out.
- Required: the second frame is accepted and transmitted fully.
- No byte from the first frame is repeated.
